// File: rtl/sprite_rom_reader.sv
// Pixel pipeline for 1-bit sprite ROMs: address generation, lit-pixel flag and frame-synchronous position updates.
// Optional blink feature enabled by defining SPRITE_BLINK_EN.
module sprite_rom_reader #(
    parameter int unsigned W            = 60,
    parameter int unsigned H            = 20,
    parameter int unsigned X_INIT       = 290,
    parameter int unsigned Y_INIT       = 230,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic [10:0] rom_addr,
    input  logic        rom_data,
    output logic        pixel_on,
    output logic [9:0]  cur_x,
    output logic [9:0]  cur_y
);

    localparam int unsigned CW    = 12;
    localparam int unsigned X_MAX = 640 - W;
    localparam int unsigned Y_MAX = 480 - H;

    // The sprite must fit the 11-bit ROM address space and blink needs a non-zero period.
    if ((W * H > 2048) || (BLINK_FRAMES == 0)) begin : g_cfg_check
        $error("sprite_rom_reader: unsupported W/H/BLINK_FRAMES configuration");
    end

    typedef enum logic {IDLE, PENDING} state_t;

    state_t     state;
    logic       sync1, sync2, sync2_d, frame_tick;
    logic       in_box_q;
    logic       visible;
    logic [9:0] pend_x, pend_y;

    // frame_clk crosses in through two flops; the registered rising edge is frame_tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync2_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync2_d    <= sync2;
            frame_tick <= sync2 & ~sync2_d;
        end
    end

    logic [CW-1:0] x_c, y_c, cx_c, cy_c, dx_c, dy_c, addr_c;
    logic          in_box_c;

    assign x_c      = CW'(DrawX);
    assign y_c      = CW'(DrawY);
    assign cx_c     = CW'(cur_x);
    assign cy_c     = CW'(cur_y);
    assign dx_c     = x_c - cx_c;
    assign dy_c     = y_c - cy_c;
    assign in_box_c = (x_c >= cx_c) && (x_c < cx_c + CW'(W)) &&
                      (y_c >= cy_c) && (y_c < cy_c + CW'(H));
    assign addr_c   = CW'(dy_c * CW'(W)) + dx_c;

    // Stage 0: ROM address; stage 1: returned bit qualified by box and visibility.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            in_box_q <= 1'b0;
            pixel_on <= 1'b0;
        end else begin
            rom_addr <= in_box_c ? 11'(addr_c) : 11'd0;
            in_box_q <= in_box_c;
            pixel_on <= in_box_q & rom_data & visible;
        end
    end

    logic [9:0] clamp_x_c, clamp_y_c;

    assign clamp_x_c = (pos_x > 10'(X_MAX)) ? 10'(X_MAX) : pos_x;
    assign clamp_y_c = (pos_y > 10'(Y_MAX)) ? 10'(Y_MAX) : pos_y;

    // Position handshake: a request is held until the next frame boundary so the sprite never tears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            pos_ready <= 1'b1;
            pend_x    <= '0;
            pend_y    <= '0;
            cur_x     <= 10'(X_INIT);
            cur_y     <= 10'(Y_INIT);
        end else begin
            case (state)
                IDLE: begin
                    if (pos_valid) begin
                        pend_x    <= clamp_x_c;
                        pend_y    <= clamp_y_c;
                        pos_ready <= 1'b0;
                        state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_tick) begin
                        cur_x     <= pend_x;
                        cur_y     <= pend_y;
                        pos_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    pos_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SPRITE_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;

    // Visibility toggles every BLINK_FRAMES frame ticks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end
`else
    assign visible = 1'b1;
`endif

endmodule

// File: doc/sprite_rom_reader.md
# sprite_rom_reader

Pixel-pipeline reader for the 1-bit bitmap sprite ROMs (60x20 font/label images such as the EXECUTE banner). It sits between the VGA controller's DrawX/DrawY scan and the color mapper. It generates the ROM address for the current pixel and registers the returned bit into a pixel-on flag. It also owns the sprite's screen position, accepts tear-free position updates through a valid/ready handshake, and applies them only at the frame boundary.

## Interface
Parameters:
- W, 60: sprite width in pixels.
- H, 20: sprite height in pixels.
- X_INIT, 290: reset X position of the top-left corner.
- Y_INIT, 230: reset Y position of the top-left corner.
- BLINK_FRAMES, 30: frames per blink half-period (used only with the blink macro).

Ports:
- Clk, input, 1: pixel clock. One clock domain only.
- Reset, input, 1: asynchronous, active-high reset.
- frame_clk, input, 1: vertical-sync-derived frame strobe. Not synchronous to Clk.
- DrawX, input, 10: current scan X, 0..639.
- DrawY, input, 10: current scan Y, 0..479.
- pos_x, input, 10: requested new X position.
- pos_y, input, 10: requested new Y position.
- pos_valid, input, 1: position request valid.
- pos_ready, output, 1: ready to accept a position request.
- rom_addr, output, 11: address to the sprite ROM `addr` port.
- rom_data, input, 1: ROM `data` bit. Combinational from rom_addr.
- pixel_on, output, 1: sprite pixel is lit at the pipelined coordinate.
- cur_x, output, 10: applied X position.
- cur_y, output, 10: applied Y position.

## Operation
- frame_clk passes through a 2-flop synchronizer followed by a rising-edge detector, producing a 1-cycle `frame_tick`.
- Stage 0, registered:
  - in_box = (DrawX ≥ cur_x) && (DrawX < cur_x+W) && (DrawY ≥ cur_y) && (DrawY < cur_y+H).
  - rom_addr = (DrawY−cur_y)*W + (DrawX−cur_x) when in_box, else 0.
  - Compute in 12-bit intermediates. The result is always ≤ W*H−1, which is 1199 at defaults.
- Stage 1, registered: pixel_on = in_box_q & rom_data & visible.
- Position handshake:
  - States: IDLE (pos_ready=1) and PENDING (pos_ready=0).
  - A transfer occurs when pos_valid && pos_ready. The request is latched into the pending registers and the state goes to PENDING.
  - In PENDING, the next frame_tick copies pending to cur_x/cur_y and returns the state to IDLE.
- Clamping happens at latch time: x is clamped to 640−W and y to 480−H. Defaults are 580 and 460. There is no wrap-around.
- Simultaneous events:
  - A transfer in the same cycle as a frame_tick while in IDLE is not applied on that tick. It waits for the next tick.
  - pos_valid held high while in PENDING is ignored.
- Reset, asserted at any time (including mid-frame or while PENDING):
  - Pending request discarded.
  - State returns to IDLE.
  - cur_x=X_INIT, cur_y=Y_INIT.
  - Synchronizer cleared.

## Timing
- Reset values: rom_addr=0, pixel_on=0, pos_ready=1, cur_x=X_INIT, cur_y=Y_INIT, visible=1, blink counter=0.
- Latency: DrawX/DrawY sampled at edge n produce rom_addr after edge n and pixel_on after edge n+1. That is 2 cycles of latency; the color mapper delays its own coordinates to match.
- Throughput: one pixel per Clk with no stalls.
- frame_tick occurs 3 Clk edges after the frame_clk rising edge (two synchronizer flops plus the edge register).
- A cur_x/cur_y change is visible in stage 0 on the cycle after frame_tick.
- pos_ready rises 1 cycle after the applying frame_tick.

## Configuration
- SPRITE_BLINK_EN defined:
  - A frame counter increments on each frame_tick.
  - When the counter reaches BLINK_FRAMES−1, it wraps to 0 and `visible` toggles.
  - pixel_on is forced to 0 while visible=0.
- SPRITE_BLINK_EN undefined:
  - The counter is not built.
  - visible is constant 1.

## Test plan
- Reset, then scan DrawX=290, DrawY=230 -> rom_addr=0 after 1 edge. pixel_on equals ROM bit 0 (0) after 2 edges. cur_x=290, cur_y=230.
- Scan DrawX=349, DrawY=249 (last sprite pixel) -> rom_addr=1199. Scan DrawX=350 -> rom_addr=0 and pixel_on=0.
- pos_x=100, pos_y=50, pos_valid pulse -> pos_ready drops the next cycle. cur_x stays 290 until the first frame_tick, then reads 100/50, and pos_ready returns to 1.
- pos_x=700, pos_y=475 -> after frame_tick, cur_x=580 and cur_y=460.
- Transfer coincident with a frame_tick -> no change on that tick; applied on the following tick. Reset while PENDING -> cur returns to 290/230 and pos_ready=1.
- SPRITE_BLINK_EN, BLINK_FRAMES=2 -> pixel_on suppressed on frames 2–3, present on frames 4–5, for an in-box lit pixel (frame index = frame_ticks since reset).
